// File: rtl/agc_instr_encoder_pkg.sv
// Shared types and constants for the AGC instruction encoder: mnemonics, field codes,
// error codes and the sequencing state type.
package agc_instr_encoder_pkg;

   typedef enum logic [4:0] {
      OP_TC, OP_RETURN, OP_TCF, OP_LXCH, OP_INCR, OP_ADS, OP_CA, OP_CS, OP_COM,
      OP_TS, OP_XCH, OP_AD, OP_MASK,
      OP_READ, OP_WRITE, OP_RAND, OP_WAND, OP_ROR, OP_WOR, OP_RXOR,
      OP_DV, OP_BZF, OP_QXCH, OP_AUG, OP_DIM, OP_HALT, OP_BZMF, OP_SU, OP_MP
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_XT_IDX, ST_IDX, ST_XT_OP, ST_OP
   } enc_state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_OP    = 2'd1;
   localparam logic [1:0] ERR_ADDR  = 2'd2;
   localparam logic [1:0] ERR_INDEX = 2'd3;

   localparam logic [14:0] EXTEND_DEFAULT = 15'o00006;
   localparam logic [2:0]  OPC_INDEX      = 3'o5;

   // op[14:12] with a full 12-bit operand
   function automatic logic [14:0] pack_a12(input logic [2:0] opc, input logic [11:0] a);
      return {opc, a};
   endfunction

   // op[14:12], quarter[11:10], erasable address
   function automatic logic [14:0] pack_q(input logic [2:0] opc, input logic [1:0] q,
                                          input logic [9:0] a);
      return {opc, q, a};
   endfunction

   // op[14:12], sub[11:9], channel
   function automatic logic [14:0] pack_ch(input logic [2:0] opc, input logic [2:0] sub,
                                           input logic [8:0] ch);
      return {opc, sub, ch};
   endfunction

endpackage

// File: rtl/agc_instr_encoder_word_pack.sv
// Combinational encoder for one instruction word: mnemonic + operand to the 15-bit word,
// plus whether an EXTEND prefix is needed and whether the operand is legal.
module agc_instr_encoder_word_pack
   import agc_instr_encoder_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [11:0] addr,
   output logic [14:0] word,
   output logic        is_extracode,
   output logic        legal,
   output logic [1:0]  err_code
);

   op_t        op_e;
   logic       op_ok;
   logic       addr_ok;
   logic       a10_ok;
   logic       ch_ok;
   logic       hi_ok;
   logic [2:0] ch_sub;

   assign op_e   = op_t'(op);
   assign a10_ok = (addr < 12'o2000);
   assign ch_ok  = (addr < 12'o1000);
   assign hi_ok  = (addr >= 12'o2000);
   assign ch_sub = 3'(op - 5'(OP_READ));

   always_comb begin
      word         = '0;
      is_extracode = 1'b0;
      op_ok        = 1'b1;
      addr_ok      = 1'b1;
      case (op_e)
         // TC to 2 or 6 would alias RETURN / EXTEND
         OP_TC:     begin word = pack_a12(3'o0, addr); addr_ok = (addr != 12'o2) && (addr != 12'o6); end
         OP_RETURN: word = 15'o00002;
         OP_TCF:    begin word = pack_a12(3'o1, addr); addr_ok = hi_ok; end
         OP_LXCH:   begin word = pack_q(3'o2, 2'd1, addr[9:0]); addr_ok = a10_ok; end
         OP_INCR:   begin word = pack_q(3'o2, 2'd2, addr[9:0]); addr_ok = a10_ok; end
         OP_ADS:    begin word = pack_q(3'o2, 2'd3, addr[9:0]); addr_ok = a10_ok; end
         OP_CA:     word = pack_a12(3'o3, addr);
         OP_CS:     word = pack_a12(3'o4, addr);
         OP_COM:    word = 15'o40000;
         OP_TS:     begin word = pack_q(3'o5, 2'd2, addr[9:0]); addr_ok = a10_ok; end
         OP_XCH:    begin word = pack_q(3'o5, 2'd3, addr[9:0]); addr_ok = a10_ok; end
         OP_AD:     word = pack_a12(3'o6, addr);
         OP_MASK:   word = pack_a12(3'o7, addr);
         OP_READ, OP_WRITE, OP_RAND, OP_WAND, OP_ROR, OP_WOR, OP_RXOR: begin
            word = pack_ch(3'o0, ch_sub, addr[8:0]); is_extracode = 1'b1; addr_ok = ch_ok;
         end
         OP_DV:     begin word = pack_q(3'o1, 2'd0, addr[9:0]); is_extracode = 1'b1; addr_ok = a10_ok; end
         OP_BZF:    begin word = pack_a12(3'o1, addr); is_extracode = 1'b1; addr_ok = hi_ok; end
         OP_QXCH:   begin word = pack_q(3'o2, 2'd1, addr[9:0]); is_extracode = 1'b1; addr_ok = a10_ok; end
         OP_AUG:    begin word = pack_q(3'o2, 2'd2, addr[9:0]); is_extracode = 1'b1; addr_ok = a10_ok; end
         OP_DIM:    begin word = pack_q(3'o2, 2'd3, addr[9:0]); is_extracode = 1'b1; addr_ok = a10_ok; end
         OP_HALT:   begin word = 15'o30000; is_extracode = 1'b1; end
         OP_BZMF:   begin word = pack_a12(3'o6, addr); is_extracode = 1'b1; addr_ok = hi_ok; end
         OP_SU:     begin word = pack_q(3'o6, 2'd0, addr[9:0]); is_extracode = 1'b1; addr_ok = a10_ok; end
         OP_MP:     begin word = pack_a12(3'o7, addr); is_extracode = 1'b1; end
         default:   op_ok = 1'b0;
      endcase
   end

   assign legal    = op_ok && addr_ok;
   assign err_code = !op_ok ? ERR_OP : (!addr_ok ? ERR_ADDR : ERR_NONE);

endmodule

// File: rtl/agc_instr_encoder.sv
// Turns a symbolic AGC request into its word stream: optional EXTEND+INDEX prefix,
// EXTEND for extracodes, then the instruction word, one word per handshake.
//
//   state     | meaning
//   ST_IDLE   | ready for a request, nothing on the output
//   ST_XT_IDX | presenting EXTEND ahead of INDEX
//   ST_IDX    | presenting INDEX idx
//   ST_XT_OP  | presenting EXTEND ahead of an extracode
//   ST_OP     | presenting the instruction word (last)
module agc_instr_encoder
   import agc_instr_encoder_pkg::*;
#(
   parameter bit          INDEX_SUPPORT = 1'b1,
   parameter logic [14:0] EXTEND_WORD   = EXTEND_DEFAULT
) (
   input  logic        clock,
   input  logic        rst_l,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [11:0] in_addr,
   input  logic        in_index_en,
   input  logic [9:0]  in_index_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [14:0] out_instr,
   output logic        out_prefix,
   output logic        out_last,
   output logic        err_valid,
   output logic [1:0]  err_code
);

   enc_state_t  state_q;
   enc_state_t  state_d;
   logic [14:0] word_q;
   logic        ext_q;
   logic [9:0]  idx_q;

   logic [14:0] pk_word;
   logic        pk_ext;
   logic        pk_legal;
   logic [1:0]  pk_err;

   logic        accept;
   logic        take;
   logic        idx_err;
   logic        req_ok;
   logic [1:0]  req_err;
   logic [14:0] word_src;
   logic [9:0]  idx_src;
   logic [14:0] instr_d;
   logic        prefix_d;
   logic        last_d;
   logic        err_valid_d;
   logic [1:0]  err_code_d;

   agc_instr_encoder_word_pack u_pack (
      .op           (in_op),
      .addr         (in_addr),
      .word         (pk_word),
      .is_extracode (pk_ext),
      .legal        (pk_legal),
      .err_code     (pk_err)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q != ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;

   assign idx_err = in_index_en && !INDEX_SUPPORT;
   assign req_ok  = pk_legal && !idx_err;
   assign req_err = (pk_err == ERR_OP) ? ERR_OP : (idx_err ? ERR_INDEX : pk_err);

   // On the accept cycle the capture registers are not loaded yet, so use the live request
   assign word_src = in_ready ? pk_word : word_q;
   assign idx_src  = in_ready ? in_index_addr : idx_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept && req_ok)
                       state_d = in_index_en ? ST_XT_IDX : (pk_ext ? ST_XT_OP : ST_OP);
         ST_XT_IDX: if (take) state_d = ST_IDX;
         ST_IDX:    if (take) state_d = ext_q ? ST_XT_OP : ST_OP;
         ST_XT_OP:  if (take) state_d = ST_OP;
         ST_OP:     if (take) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      instr_d  = '0;
      prefix_d = 1'b0;
      last_d   = 1'b0;
      case (state_d)
         ST_XT_IDX, ST_XT_OP: begin instr_d = EXTEND_WORD; prefix_d = 1'b1; end
         ST_IDX:  begin instr_d = {OPC_INDEX, 2'b00, idx_src}; prefix_d = 1'b1; end
         ST_OP:   begin instr_d = word_src; last_d = 1'b1; end
         default: ;
      endcase

      err_valid_d = accept && !req_ok;
      err_code_d  = err_valid_d ? req_err : ERR_NONE;
   end

   always_ff @(posedge clock) begin
      if (!rst_l) begin
         state_q    <= ST_IDLE;
         out_instr  <= '0;
         out_prefix <= 1'b0;
         out_last   <= 1'b0;
         err_valid  <= 1'b0;
         err_code   <= ERR_NONE;
         word_q     <= '0;
         ext_q      <= 1'b0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         out_instr  <= instr_d;
         out_prefix <= prefix_d;
         out_last   <= last_d;
         err_valid  <= err_valid_d;
         err_code   <= err_code_d;
         if (accept) begin
            word_q <= pk_word;
            ext_q  <= pk_ext;
            idx_q  <= in_index_addr;
         end
      end
   end

endmodule

// File: tb/tb_agc_instr_encoder.sv
// Scoreboard bench for agc_instr_encoder: a word-level reference model fills expected
// queues at request time, an independent monitor pops and compares at each handshake.
module tb_agc_instr_encoder;

   logic        clock = 1'b0;
   logic        rst_l;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [11:0] in_addr;
   logic        in_index_en;
   logic [9:0]  in_index_addr;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] out_instr;
   logic        out_prefix;
   logic        out_last;
   logic        err_valid;
   logic [1:0]  err_code;

   // second instance built without INDEX support
   logic        ni_in_valid;
   logic        ni_in_ready;
   logic [4:0]  ni_in_op;
   logic [11:0] ni_in_addr;
   logic        ni_in_index_en;
   logic [9:0]  ni_in_index_addr;
   logic        ni_out_valid;
   logic        ni_out_ready;
   logic [14:0] ni_out_instr;
   logic        ni_out_prefix;
   logic        ni_out_last;
   logic        ni_err_valid;
   logic [1:0]  ni_err_code;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];
   int err_q[$];
   int ready_mode = 0;
   int stall_cnt  = 0;

   always #5 clock = ~clock;

   agc_instr_encoder dut (
      .clock(clock), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_addr(in_addr), .in_index_en(in_index_en),
      .in_index_addr(in_index_addr), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_prefix(out_prefix), .out_last(out_last),
      .err_valid(err_valid), .err_code(err_code)
   );

   agc_instr_encoder #(.INDEX_SUPPORT(1'b0)) dut_ni (
      .clock(clock), .rst_l(rst_l), .in_valid(ni_in_valid), .in_ready(ni_in_ready),
      .in_op(ni_in_op), .in_addr(ni_in_addr), .in_index_en(ni_in_index_en),
      .in_index_addr(ni_in_index_addr), .out_valid(ni_out_valid), .out_ready(ni_out_ready),
      .out_instr(ni_out_instr), .out_prefix(ni_out_prefix), .out_last(ni_out_last),
      .err_valid(ni_err_valid), .err_code(ni_err_code)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0o, expected %0o (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int pk(input int w, input int p, input int l);
      return w | (p << 15) | (l << 16);
   endfunction

   // Reference model: octal word values straight from the instruction set table.
   // Returns 0 legal, 1 unknown op, 2 operand out of range.
   function automatic int model_word(input int op, input int a, output int w, output bit ext);
      int err;
      err = 0;
      w   = 0;
      ext = (op >= 13 && op <= 28);
      case (op)
         0:  begin w = a; if (a == 2 || a == 6) err = 2; end
         1:  w = 'o2;
         2:  begin w = 'o10000 + a; if (a < 'o2000) err = 2; end
         3, 4, 5: begin w = 'o20000 + (op - 2) * 'o2000 + a; if (a >= 'o2000) err = 2; end
         6:  w = 'o30000 + a;
         7:  w = 'o40000 + a;
         8:  w = 'o40000;
         9, 10: begin w = 'o50000 + (op - 7) * 'o2000 + a; if (a >= 'o2000) err = 2; end
         11: w = 'o60000 + a;
         12: w = 'o70000 + a;
         13, 14, 15, 16, 17, 18, 19: begin
            w = (op - 13) * 'o1000 + a; if (a >= 'o1000) err = 2;
         end
         20: begin w = 'o10000 + a; if (a >= 'o2000) err = 2; end
         21: begin w = 'o10000 + a; if (a < 'o2000) err = 2; end
         22, 23, 24: begin w = 'o20000 + (op - 21) * 'o2000 + a; if (a >= 'o2000) err = 2; end
         25: w = 'o30000;
         26: begin w = 'o60000 + a; if (a < 'o2000) err = 2; end
         27: begin w = 'o60000 + a; if (a >= 'o2000) err = 2; end
         28: w = 'o70000 + a;
         default: err = 1;
      endcase
      return err;
   endfunction

   function automatic int model_err(input int op, input int a, input bit ien, input bit index_ok);
      int w;
      bit ext;
      int err;
      err = model_word(op, a, w, ext);
      if (err != 1 && ien && !index_ok) err = 3;
      return err;
   endfunction

   task automatic expect_req(input int op, input int a, input bit ien, input int idx);
      int w;
      bit ext;
      int err;
      err = model_word(op, a, w, ext);
      if (err != 0) err_q.push_back(err);
      else begin
         if (ien) begin
            exp_q.push_back(pk(6, 1, 0));
            exp_q.push_back(pk('o50000 + idx, 1, 0));
         end
         if (ext) exp_q.push_back(pk(6, 1, 0));
         exp_q.push_back(pk(w, 0, 1));
      end
   endtask

   // Returns at the falling edge right after the accept edge.
   task automatic send(input int op, input int a, input bit ien, input int idx);
      int guard;
      guard = 0;
      @(negedge clock);
      while (!in_ready && guard < 500) begin
         in_valid      = ($urandom_range(0, 2) == 0);
         in_op         = 5'($urandom);
         in_addr       = 12'($urandom);
         in_index_en   = 1'($urandom);
         in_index_addr = 10'($urandom);
         @(negedge clock);
         guard++;
      end
      check("in_ready_wait", int'(guard < 500), 1);
      expect_req(op, a, ien, idx);
      in_valid      = 1'b1;
      in_op         = 5'(op);
      in_addr       = 12'(a);
      in_index_en   = ien;
      in_index_addr = 10'(idx);
      @(negedge clock);
      in_valid      = 1'b0;
      in_op         = 5'($urandom);
      in_addr       = 12'($urandom);
      in_index_en   = 1'($urandom);
      in_index_addr = 10'($urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || err_q.size() != 0 || !in_ready) && guard < 2000) begin
         @(negedge clock);
         #2;
         guard++;
      end
      check("drain_wait", int'(guard < 2000), 1);
   endtask

   task automatic ni_send(input int op, input int a, input bit ien);
      int exp;
      exp = model_err(op, a, ien, 1'b0);
      @(negedge clock);
      ni_in_valid = 1'b1; ni_in_op = 5'(op); ni_in_addr = 12'(a); ni_in_index_en = ien;
      ni_in_index_addr = 10'o40;
      @(negedge clock);
      ni_in_valid = 1'b0;
      check("ni_err_valid", int'(ni_err_valid), int'(exp != 0));
      check("ni_err_code", int'(ni_err_code), exp);
      if (exp == 0) check("ni_word", pk(int'(ni_out_instr), int'(ni_out_prefix), int'(ni_out_last)), pk('o30100, 0, 1));
      else check("ni_no_word", int'(ni_out_valid), 0);
      @(negedge clock);
   endtask

   // out_ready driver: changes just after the rising edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
               out_ready = (stall_cnt == 3);
               stall_cnt = (stall_cnt == 3) ? 0 : stall_cnt + 1;
            end
         endcase
      end
   end

   // Monitor
   int          mon_e;
   bit          prev_stall = 1'b0;
   logic [14:0] prev_instr;
   logic        prev_prefix;
   logic        prev_last;

   always @(negedge clock) begin
      if (!rst_l) prev_stall = 1'b0;
      else begin
         if (prev_stall)
            check("hold_stable", pk(int'(out_instr), int'(out_prefix), int'(out_last)) | (int'(out_valid) << 17),
                  pk(int'(prev_instr), int'(prev_prefix), int'(prev_last)) | (1 << 17));
         if (out_valid) check("in_ready_busy", int'(in_ready), 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_word", pk(int'(out_instr), int'(out_prefix), int'(out_last)), -1);
            else begin
               mon_e = exp_q.pop_front();
               check("word", pk(int'(out_instr), int'(out_prefix), int'(out_last)), mon_e);
            end
         end
         if (err_valid) begin
            if (err_q.size() == 0) check("unexpected_err", int'(err_code), -1);
            else begin
               mon_e = err_q.pop_front();
               check("err_code", int'(err_code), mon_e);
            end
         end
         prev_stall  = out_valid && !out_ready;
         prev_instr  = out_instr;
         prev_prefix = out_prefix;
         prev_last   = out_last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int bvals[8];
      int op, a, sel;
      bit ien;
      bvals = '{0, 2, 6, 'o777, 'o1000, 'o1777, 'o2000, 'o7777};

      rst_l = 1'b0;
      in_valid = 1'b0; in_op = '0; in_addr = '0; in_index_en = 1'b0; in_index_addr = '0;
      ni_in_valid = 1'b0; ni_in_op = '0; ni_in_addr = '0; ni_in_index_en = 1'b0;
      ni_in_index_addr = '0; ni_out_ready = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_regs", pk(int'(out_instr), int'(out_prefix), int'(out_last)) | (int'(err_valid) << 17) | (int'(err_code) << 18), 0);
      #2 rst_l = 1'b1;

      // single-word timing
      ready_mode = 0;
      send(6, 'o100, 0, 0);
      check("ca_out_valid_n1", int'(out_valid), 1);
      check("ca_in_ready_n1", int'(in_ready), 0);
      @(negedge clock);
      check("ca_in_ready_n2", int'(in_ready), 1);
      check("ca_out_valid_n2", int'(out_valid), 0);

      // rejected request timing
      send(2, 'o1000, 0, 0);
      check("tcf_err_valid", int'(err_valid), 1);
      check("tcf_err_code", int'(err_code), 2);
      check("tcf_no_out", int'(out_valid), 0);
      check("tcf_in_ready", int'(in_ready), 1);
      drain();

      send(13, 'o15, 0, 0);
      send(24, 'o77, 0, 0);
      send(0, 'o6, 0, 0);
      send(27, 'o2000, 0, 0);
      send(31, 'o100, 1, 'o40);
      send(21, 'o2000, 0, 0);
      send(26, 'o7777, 0, 0);
      drain();

      // backpressure: each word held for several cycles
      ready_mode = 2;
      send(9, 'o50, 1, 'o40);
      send(28, 'o300, 1, 'o40);
      drain();

      // reset after the second word of a four-word sequence
      ready_mode = 0;
      send(28, 'o300, 1, 'o40);
      #2;
      guard = 0;
      while (exp_q.size() > 1 && guard < 20) begin
         @(negedge clock);
         #2;
         guard++;
      end
      check("rst_seq_wait", int'(guard < 20), 1);
      rst_l = 1'b0;
      exp_q.delete();
      @(negedge clock);
      check("rst_mid_out_valid", int'(out_valid), 0);
      check("rst_mid_in_ready", int'(in_ready), 1);
      check("rst_mid_regs", pk(int'(out_instr), int'(out_prefix), int'(out_last)), 0);
      #2 rst_l = 1'b1;
      repeat (4) @(negedge clock);

      // no-INDEX build
      ni_send(6, 'o100, 1'b1);
      ni_send(31, 'o100, 1'b1);
      ni_send(2, 'o1000, 1'b1);
      ni_send(6, 'o100, 1'b0);

      // randomized traffic with random backpressure
      ready_mode = 1;
      for (int i = 0; i < 300; i++) begin
         op  = ($urandom_range(0, 9) == 0) ? $urandom_range(29, 31) : $urandom_range(0, 28);
         sel = $urandom_range(0, 8);
         a   = (sel == 8) ? $urandom_range(0, 'o7777) : bvals[sel];
         ien = ($urandom_range(0, 3) == 0);
         send(op, a, ien, $urandom_range(0, 1023));
      end
      ready_mode = 0;
      drain();
      repeat (4) @(negedge clock);
      check("final_words_left", exp_q.size(), 0);
      check("final_errs_left", err_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
